id_ex_hazard_ctrl: RTL and testbench
====================================

# id_ex_hazard_ctrl

Sits between the RV32I decoder and the execute stage. Owns the ID/EX pipeline register and is the producer of the decoder's `buble` input: it detects read-after-write hazards against in-flight instructions, handles branch flushes and execute back-pressure, and tells fetch to hold. It consumes the 26-bit control word and the 3-bit `branch_sel` the decoder emits.

## Interface
- `FLUSH_DEPTH`, default 1: extra bubble cycles after a flush, to squash wrong-path fetch slots.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `id_rs1`  in  5  raw instruction[19:15] from the fetch/ID register. Not taken from the control word, so there is no loop through `buble`.
- `id_rs2`  in  5  raw instruction[24:20]
- `id_valid`  in  1  ID holds a real instruction
- `id_control_word`  in  26  decoder output: [25:21] d_addr, [20:16] b_sel, [15:11] a_sel, [10:7] func, [6] we, [5] save_pc, [4] load, [3] use_imm, [2:0] mem_width
- `id_branch_sel`  in  3  decoder branch selection
- `ex_ready`  in  1  execute accepts the ID/EX contents this cycle
- `flush`  in  1  taken branch/jump resolved in EX
- `buble`  out  1  to the decoder; forces a zero control word
- `stall_if`  out  1  hold the PC and the IF/ID register
- `ex_valid`  out  1  ID/EX holds a real instruction
- `ex_control_word`  out  26  registered control word
- `ex_branch_sel`  out  3  registered branch selection

## Operation
- Hazard compare:
  - Source fields are `id_rs1` and `id_rs2` when `id_valid`.
  - Comparison is conservative: both sources are always compared, and register x0 never matches.
  - A producer stage matches when its `we`=1 and its d_addr equals a source field.
- Shadow registers: `mem_we`, `mem_load`, `mem_d_addr` capture the EX fields when EX advances. They are cleared on reset.
- State machine states: RUN, STALL, FLUSH.
  - RUN:
    - On hazard: `buble`=1, `stall_if`=1, and ID/EX loads zero with `ex_valid`=0. Stay in RUN; the hazard is re-evaluated each cycle, and STALL is used only for the `ex_ready` freeze.
  - STALL (entered when `ex_ready`=0):
    - ID/EX and the shadow registers hold.
    - `stall_if`=1, `buble`=0.
    - Return to RUN when `ex_ready`=1.
  - FLUSH (entered when `flush`=1, from any state):
    - ID/EX loads zero.
    - `buble`=1 for the flush cycle plus `FLUSH_DEPTH` following cycles, counted by a `$clog2(FLUSH_DEPTH+1)`-bit down-counter.
    - `stall_if`=0.
    - Return to RUN when the counter reaches 0.
- Priority: `flush` > `ex_ready`=0 freeze > hazard > normal advance.
- Normal advance:
  - ID/EX loads `id_control_word`/`id_branch_sel`.
  - `ex_valid`=`id_valid`.
  - Whenever a bubble is inserted, the control word is forced to 0 internally, regardless of the decoder output.
- A `flush` arriving during a FLUSH countdown reloads the counter.

## Timing
- Reset values: `ex_control_word`=0, `ex_branch_sel`=0, `ex_valid`=0, shadow registers 0, state RUN, counter 0.
- Outputs after reset: `buble`=0, `stall_if`=0.
- `buble` and `stall_if` are combinational from registered state plus `id_rs*`, `id_valid`, `ex_ready`, `flush`. There is no path from `id_control_word`.
- ID/EX latency: 1 cycle.
- Load-use stall with forwarding: exactly 1 bubble.
- Reset asserted mid-stall or mid-flush: immediate return to reset values; no pending bubble survives.

## Configuration
- Macro: `ID_EX_FORWARDING_EN`.
- Defined:
  - Only a load in EX matching a source stalls.
  - ALU results are assumed forwarded.
  - Maximum stall: 1 cycle.
- Undefined:
  - Any `we`=1 producer in EX or MEM matching a source stalls.
  - The register file writes before it reads, so WB needs no stall.
  - Maximum stall: 2 cycles.
  - The MEM shadow `mem_load` is unused in this mode.

## Structure
- `decode_pkg` holds:
  - control-word field MSB/LSB localparams;
  - the state enum `hz_state_t` {RUN, STALL, FLUSH};
  - the `branch_sel` encodings (000 none, 010 BEQ, 011 BNE, 100 BLT, 101 BGE, 110 JAL, 111 JALR).
- One sub-module, `rv32i_hazard_detect`: combinational source/destination compare. It takes the EX and MEM fields and returns `hazard`. The forwarding macro is evaluated inside it.

## Test plan
- Load-use, forwarding on: `lw x5` in ID then `add x6,x5,x1` → 1 cycle of `buble`=1 and `stall_if`=1. EX shows 0 for one cycle, then the add with a_sel=5.
- No forwarding: `addi x3,x0,1` then `sub x4,x3,x3` → 2 bubble cycles. EX then receives the sub.
- x0 producer: `addi x0,x0,5` then `add x1,x0,x0` → no stall, back-to-back issue.
- Flush with `FLUSH_DEPTH`=1 while a hazard is pending → `buble`=1 for 2 cycles, `stall_if`=0, `ex_valid`=0 for 2 cycles, flush wins over the hazard.
- `ex_ready`=0 for 3 cycles with `beq` in EX → `ex_control_word`/`ex_branch_sel`=010 held, `stall_if`=1, `buble`=0. The next instruction advances on the cycle `ex_ready` returns.
- Reset asserted during the second no-forwarding stall cycle → `ex_valid`=0 and `buble`=0 immediately. The first instruction after release issues without a stall.

Source files
------------

// File: rtl/decode_pkg.sv
//==============================================================================
// Module      : decode_pkg
// Description : Shared definitions for the RV32I decode / ID-EX boundary:
//               control-word field positions, hazard controller state
//               encoding, branch_sel encodings and a register-compare helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package decode_pkg;

    // Control-word layout (26 bits)
    localparam int unsigned c_CW_W         = 26;
    localparam int unsigned c_CW_DADDR_MSB = 25;
    localparam int unsigned c_CW_DADDR_LSB = 21;
    localparam int unsigned c_CW_BSEL_MSB  = 20;
    localparam int unsigned c_CW_BSEL_LSB  = 16;
    localparam int unsigned c_CW_ASEL_MSB  = 15;
    localparam int unsigned c_CW_ASEL_LSB  = 11;
    localparam int unsigned c_CW_FUNC_MSB  = 10;
    localparam int unsigned c_CW_FUNC_LSB  = 7;
    localparam int unsigned c_CW_WE_BIT    = 6;
    localparam int unsigned c_CW_SPC_BIT   = 5;
    localparam int unsigned c_CW_LOAD_BIT  = 4;
    localparam int unsigned c_CW_IMM_BIT   = 3;
    localparam int unsigned c_CW_MW_MSB    = 2;
    localparam int unsigned c_CW_MW_LSB    = 0;

    localparam int unsigned c_REG_W  = 5;
    localparam int unsigned c_BSEL_W = 3;

    // Hazard controller states
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_t;

    // branch_sel encodings
    localparam logic [c_BSEL_W-1:0] c_BR_NONE = 3'b000;
    localparam logic [c_BSEL_W-1:0] c_BR_BEQ  = 3'b010;
    localparam logic [c_BSEL_W-1:0] c_BR_BNE  = 3'b011;
    localparam logic [c_BSEL_W-1:0] c_BR_BLT  = 3'b100;
    localparam logic [c_BSEL_W-1:0] c_BR_BGE  = 3'b101;
    localparam logic [c_BSEL_W-1:0] c_BR_JAL  = 3'b110;
    localparam logic [c_BSEL_W-1:0] c_BR_JALR = 3'b111;

    // x0 is hard-wired zero, so it never carries a dependency.
    function automatic logic src_match(input logic [c_REG_W-1:0] src,
                                       input logic [c_REG_W-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_hazard_detect.sv
//==============================================================================
// Module      : rv32i_hazard_detect
// Description : Combinational read-after-write compare of the ID source fields
//               against the producers in EX and MEM.
//               Macro ID_EX_FORWARDING_EN: when defined only a load in EX
//               stalls (ALU results forwarded); otherwise any writing
//               producer in EX or MEM stalls.
// Ports       : i_id_valid, i_id_rs1, i_id_rs2  - consumer sources
//               i_ex_we, i_ex_load, i_ex_d_addr - EX producer fields
//               i_mem_we, i_mem_load, i_mem_d_addr - MEM producer fields
//               o_hazard - dependency requires a bubble
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rv32i_hazard_detect
    import decode_pkg::*;
(
    input  logic               i_id_valid,
    input  logic [c_REG_W-1:0] i_id_rs1,
    input  logic [c_REG_W-1:0] i_id_rs2,
    input  logic               i_ex_we,
    input  logic               i_ex_load,
    input  logic [c_REG_W-1:0] i_ex_d_addr,
    input  logic               i_mem_we,
    input  logic               i_mem_load,
    input  logic [c_REG_W-1:0] i_mem_d_addr,
    output logic               o_hazard
);

    logic w_ex_hit;
    logic w_mem_hit;

    // Both sources are compared for every instruction, whether or not the
    // opcode actually reads them.
    assign w_ex_hit  = i_ex_we  && (src_match(i_id_rs1, i_ex_d_addr)  ||
                                    src_match(i_id_rs2, i_ex_d_addr));
    assign w_mem_hit = i_mem_we && (src_match(i_id_rs1, i_mem_d_addr) ||
                                    src_match(i_id_rs2, i_mem_d_addr));

`ifdef ID_EX_FORWARDING_EN
    // ALU results are forwarded; only load data is late by one cycle.
    assign o_hazard = i_id_valid && w_ex_hit && i_ex_load;

    logic w_unused_fwd;
    assign w_unused_fwd = ^{w_mem_hit, i_mem_load};
`else
    // WB writes before ID reads, so EX and MEM are the only conflicts.
    assign o_hazard = i_id_valid && (w_ex_hit || w_mem_hit);

    logic w_unused_nofwd;
    assign w_unused_nofwd = ^{i_ex_load, i_mem_load};
`endif

endmodule

`default_nettype wire

// File: rtl/id_ex_hazard_ctrl.sv
//==============================================================================
// Module      : id_ex_hazard_ctrl
// Description : ID/EX pipeline register with RAW hazard bubbles, branch flush
//               and execute back-pressure. Drives the decoder's buble input
//               and the fetch hold.
//               Macro ID_EX_FORWARDING_EN selects the forwarding hazard rules.
// Ports       : clk, reset (async, active-high)
//               id_rs1/id_rs2/id_valid - raw sources from IF/ID
//               id_control_word/id_branch_sel - decoder outputs
//               ex_ready, flush - execute-side controls
//               buble, stall_if - combinational pipeline controls
//               ex_valid/ex_control_word/ex_branch_sel - ID/EX register
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module id_ex_hazard_ctrl
    import decode_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 1
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [c_REG_W-1:0]  id_rs1,
    input  logic [c_REG_W-1:0]  id_rs2,
    input  logic                id_valid,
    input  logic [c_CW_W-1:0]   id_control_word,
    input  logic [c_BSEL_W-1:0] id_branch_sel,
    input  logic                ex_ready,
    input  logic                flush,
    output logic                buble,
    output logic                stall_if,
    output logic                ex_valid,
    output logic [c_CW_W-1:0]   ex_control_word,
    output logic [c_BSEL_W-1:0] ex_branch_sel
);

    localparam int unsigned c_CNT_W = (FLUSH_DEPTH > 0) ? $clog2(FLUSH_DEPTH + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(FLUSH_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    hz_state_t            r_state;
    logic [c_CNT_W-1:0]   r_flush_cnt;
    logic                 r_ex_valid;
    logic [c_CW_W-1:0]    r_ex_cw;
    logic [c_BSEL_W-1:0]  r_ex_bsel;
    logic                 r_mem_we;
    logic                 r_mem_load;
    logic [c_REG_W-1:0]   r_mem_d_addr;

    logic                 w_hazard;
    logic                 w_flushing;
    logic                 w_freeze;
    logic                 w_hz_bubble;
    logic [c_CW_W-1:0]    w_id_cw;
    logic [c_BSEL_W-1:0]  w_id_bsel;

    rv32i_hazard_detect u_hazard_detect (
        .i_id_valid   (id_valid),
        .i_id_rs1     (id_rs1),
        .i_id_rs2     (id_rs2),
        .i_ex_we      (r_ex_cw[c_CW_WE_BIT]),
        .i_ex_load    (r_ex_cw[c_CW_LOAD_BIT]),
        .i_ex_d_addr  (r_ex_cw[c_CW_DADDR_MSB:c_CW_DADDR_LSB]),
        .i_mem_we     (r_mem_we),
        .i_mem_load   (r_mem_load),
        .i_mem_d_addr (r_mem_d_addr),
        .o_hazard     (w_hazard)
    );

    // Priority: flush (incl. countdown) > ex_ready freeze > hazard > advance.
    assign w_flushing  = flush || (r_state == FLUSH);
    assign w_freeze    = !w_flushing && !ex_ready;
    assign w_hz_bubble = !w_flushing && ex_ready && w_hazard;

    assign buble    = w_flushing || w_hz_bubble;
    assign stall_if = w_freeze || w_hz_bubble;

    // A bubble is zero regardless of what the decoder presents.
    assign w_id_cw   = buble ? '0 : id_control_word;
    assign w_id_bsel = buble ? '0 : id_branch_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= RUN;
            r_flush_cnt  <= '0;
            r_ex_valid   <= 1'b0;
            r_ex_cw      <= '0;
            r_ex_bsel    <= '0;
            r_mem_we     <= 1'b0;
            r_mem_load   <= 1'b0;
            r_mem_d_addr <= '0;
        end else begin
            // A new flush always (re)loads the countdown, even mid-countdown.
            if (flush) begin
                r_state     <= (FLUSH_DEPTH > 0) ? FLUSH : RUN;
                r_flush_cnt <= c_CNT_LOAD;
            end else if (r_state == FLUSH) begin
                r_flush_cnt <= r_flush_cnt - c_CNT_ONE;
                if (r_flush_cnt <= c_CNT_ONE) begin
                    r_state <= RUN;
                end
            end else if (!ex_ready) begin
                r_state <= STALL;
            end else begin
                r_state <= RUN;
            end

            if (!w_freeze) begin
                r_ex_valid <= id_valid && !buble;
                r_ex_cw    <= w_id_cw;
                r_ex_bsel  <= w_id_bsel;
            end

            // MEM shadow follows EX only when EX hands its contents on.
            if (ex_ready) begin
                r_mem_we     <= r_ex_cw[c_CW_WE_BIT];
                r_mem_load   <= r_ex_cw[c_CW_LOAD_BIT];
                r_mem_d_addr <= r_ex_cw[c_CW_DADDR_MSB:c_CW_DADDR_LSB];
            end
        end
    end

    assign ex_valid        = r_ex_valid;
    assign ex_control_word = r_ex_cw;
    assign ex_branch_sel   = r_ex_bsel;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_hazard_ctrl.sv
//==============================================================================
// Module      : tb_id_ex_hazard_ctrl
// Description : Directed self-checking bench for id_ex_hazard_ctrl.
//               Expectations follow ID_EX_FORWARDING_EN when it is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_id_ex_hazard_ctrl;
    import decode_pkg::*;

`ifdef ID_EX_FORWARDING_EN
    localparam int c_NB_ALU  = 0;
    localparam int c_NB_LOAD = 1;
`else
    localparam int c_NB_ALU  = 2;
    localparam int c_NB_LOAD = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic        id_valid = 1'b0;
    logic [25:0] id_control_word = '0;
    logic [2:0]  id_branch_sel = '0;
    logic        ex_ready = 1'b1;
    logic        flush = 1'b0;
    logic        buble;
    logic        stall_if;
    logic        ex_valid;
    logic [25:0] ex_control_word;
    logic [2:0]  ex_branch_sel;

    int n_total = 0;
    int n_bad   = 0;

    id_ex_hazard_ctrl #(.FLUSH_DEPTH(1)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_valid        (id_valid),
        .id_control_word (id_control_word),
        .id_branch_sel   (id_branch_sel),
        .ex_ready        (ex_ready),
        .flush           (flush),
        .buble           (buble),
        .stall_if        (stall_if),
        .ex_valid        (ex_valid),
        .ex_control_word (ex_control_word),
        .ex_branch_sel   (ex_branch_sel)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] mk_cw(input logic [4:0] d, input logic [4:0] b,
                                          input logic [4:0] a, input logic [3:0] fn,
                                          input logic we, input logic spc, input logic ld,
                                          input logic imm, input logic [2:0] mw);
        return {d, b, a, fn, we, spc, ld, imm, mw};
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [25:0] cw, input logic [2:0] bs,
                         input logic rdy, input logic fl);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_control_word = cw;
        id_branch_sel = bs; ex_ready = rdy; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 26'd0, 3'd0, 1'b1, 1'b0);
        tick(); tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 5'd5, 5'd6, mk_cw(5'd7, 5'd6, 5'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0), 3'b010, 1'b1, 1'b0);
        tick(); tick();
        @(negedge clk);
        n_total++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ex_valid got=%0h exp=0", ex_valid); end
        n_total++; if (ex_control_word !== 26'd0) begin n_bad++; $display("FAIL reset_ex_cw got=%0h exp=0", ex_control_word); end
        n_total++; if (ex_branch_sel !== 3'd0) begin n_bad++; $display("FAIL reset_ex_bsel got=%0h exp=0", ex_branch_sel); end
        n_total++; if (buble !== 1'b0) begin n_bad++; $display("FAIL reset_buble got=%0h exp=0", buble); end
        n_total++; if (stall_if !== 1'b0) begin n_bad++; $display("FAIL reset_stall_if got=%0h exp=0", stall_if); end
        @(posedge clk); #1;
        reset = 1'b0;
        idle();
    endtask

    // addi x3,x0,1 then sub x4,x3,x3
    task automatic test_no_fwd();
        logic [25:0] addi_cw;
        logic [25:0] sub_cw;
        logic        exp_b;
        addi_cw = mk_cw(5'd3, 5'd1, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        sub_cw  = mk_cw(5'd4, 5'd3, 5'd3, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b1, 5'd0, 5'd1, addi_cw, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_total++; if (buble !== 1'b0) begin n_bad++; $display("FAIL alu_first_buble got=%0h exp=0", buble); end
        tick();
        for (int k = 0; k <= c_NB_ALU; k++) begin
            drive(1'b1, 5'd3, 5'd3, sub_cw, 3'd0, 1'b1, 1'b0);
            @(negedge clk);
            exp_b = (k < c_NB_ALU);
            n_total++; if (buble !== exp_b) begin n_bad++; $display("FAIL alu_buble[%0d] got=%0h exp=%0h", k, buble, exp_b); end
            n_total++; if (stall_if !== exp_b) begin n_bad++; $display("FAIL alu_stall_if[%0d] got=%0h exp=%0h", k, stall_if, exp_b); end
            if (k == 0) begin
                n_total++; if (ex_control_word !== addi_cw) begin n_bad++; $display("FAIL alu_ex_addi got=%0h exp=%0h", ex_control_word, addi_cw); end
            end else begin
                n_total++; if (ex_valid !== 1'b0 || ex_control_word !== 26'd0) begin n_bad++; $display("FAIL alu_ex_bubble[%0d] got=%0h/%0h exp=0/0", k, ex_valid, ex_control_word); end
            end
            tick();
        end
        drive(1'b0, 5'd0, 5'd0, 26'd0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_total++; if (ex_control_word !== sub_cw) begin n_bad++; $display("FAIL alu_ex_sub got=%0h exp=%0h", ex_control_word, sub_cw); end
        n_total++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL alu_ex_sub_valid got=%0h exp=1", ex_valid); end
        tick();
        idle();
    endtask

    // lw x5,0(x10) then add x6,x5,x1
    task automatic test_load_use();
        logic [25:0] lw_cw;
        logic [25:0] add_cw;
        logic        exp_b;
        lw_cw  = mk_cw(5'd5, 5'd0, 5'd10, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010);
        add_cw = mk_cw(5'd6, 5'd1, 5'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b1, 5'd10, 5'd0, lw_cw, 3'd0, 1'b1, 1'b0);
        tick();
        for (int k = 0; k <= c_NB_LOAD; k++) begin
            drive(1'b1, 5'd5, 5'd1, add_cw, 3'd0, 1'b1, 1'b0);
            @(negedge clk);
            exp_b = (k < c_NB_LOAD);
            n_total++; if (buble !== exp_b) begin n_bad++; $display("FAIL ld_buble[%0d] got=%0h exp=%0h", k, buble, exp_b); end
            n_total++; if (stall_if !== exp_b) begin n_bad++; $display("FAIL ld_stall_if[%0d] got=%0h exp=%0h", k, stall_if, exp_b); end
            if (k > 0) begin
                n_total++; if (ex_control_word !== 26'd0) begin n_bad++; $display("FAIL ld_ex_zero[%0d] got=%0h exp=0", k, ex_control_word); end
            end
            tick();
        end
        drive(1'b0, 5'd0, 5'd0, 26'd0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_total++; if (ex_control_word !== add_cw) begin n_bad++; $display("FAIL ld_ex_add got=%0h exp=%0h", ex_control_word, add_cw); end
        n_total++; if (ex_control_word[15:11] !== 5'd5) begin n_bad++; $display("FAIL ld_ex_asel got=%0h exp=5", ex_control_word[15:11]); end
        tick();
        idle();
    endtask

    // addi x0,x0,5 then add x1,x0,x0
    task automatic test_x0();
        logic [25:0] addi0_cw;
        logic [25:0] add1_cw;
        addi0_cw = mk_cw(5'd0, 5'd5, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        add1_cw  = mk_cw(5'd1, 5'd0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b1, 5'd0, 5'd5, addi0_cw, 3'd0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, add1_cw, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_total++; if (buble !== 1'b0) begin n_bad++; $display("FAIL x0_buble got=%0h exp=0", buble); end
        n_total++; if (stall_if !== 1'b0) begin n_bad++; $display("FAIL x0_stall_if got=%0h exp=0", stall_if); end
        n_total++; if (ex_control_word !== addi0_cw) begin n_bad++; $display("FAIL x0_ex_addi got=%0h exp=%0h", ex_control_word, addi0_cw); end
        tick();
        drive(1'b0, 5'd0, 5'd0, 26'd0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_total++; if (ex_control_word !== add1_cw || ex_valid !== 1'b1) begin n_bad++; $display("FAIL x0_ex_add got=%0h/%0h exp=%0h/1", ex_control_word, ex_valid, add1_cw); end
        tick();
        idle();
    endtask

    // Flush arrives while sub x4,x3,x3 waits on addi x3
    task automatic test_flush();
        logic [25:0] addi_cw;
        logic [25:0] sub_cw;
        logic [25:0] add1_cw;
        addi_cw = mk_cw(5'd3, 5'd1, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
        sub_cw  = mk_cw(5'd4, 5'd3, 5'd3, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        add1_cw = mk_cw(5'd1, 5'd0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b1, 5'd0, 5'd1, addi_cw, 3'd0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd3, sub_cw, 3'd0, 1'b1, 1'b1);
        @(negedge clk);
        n_total++; if (buble !== 1'b1) begin n_bad++; $display("FAIL fl_c0_buble got=%0h exp=1", buble); end
        n_total++; if (stall_if !== 1'b0) begin n_bad++; $display("FAIL fl_c0_stall_if got=%0h exp=0", stall_if); end
        tick();
        drive(1'b1, 5'd3, 5'd3, sub_cw, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_total++; if (buble !== 1'b1) begin n_bad++; $display("FAIL fl_c1_buble got=%0h exp=1", buble); end
        n_total++; if (stall_if !== 1'b0) begin n_bad++; $display("FAIL fl_c1_stall_if got=%0h exp=0", stall_if); end
        n_total++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL fl_c1_ex_valid got=%0h exp=0", ex_valid); end
        tick();
        drive(1'b1, 5'd0, 5'd0, add1_cw, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_total++; if (buble !== 1'b0) begin n_bad++; $display("FAIL fl_c2_buble got=%0h exp=0", buble); end
        n_total++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL fl_c2_ex_valid got=%0h exp=0", ex_valid); end
        tick();
        drive(1'b0, 5'd0, 5'd0, 26'd0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_total++; if (ex_control_word !== add1_cw || ex_valid !== 1'b1) begin n_bad++; $display("FAIL fl_target got=%0h/%0h exp=%0h/1", ex_control_word, ex_valid, add1_cw); end
        tick();
        idle();
    endtask

    // Second flush during the countdown extends the bubble train
    task automatic test_flush_reload();
        logic [25:0] add1_cw;
        add1_cw = mk_cw(5'd1, 5'd0, 5'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b1, 5'd0, 5'd0, add1_cw, 3'd0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd0, 5'd0, add1_cw, 3'd0, 1'b1, 1'b1);
        @(negedge clk);
        n_total++; if (buble !== 1'b1 || stall_if !== 1'b0) begin n_bad++; $display("FAIL rl_c1 got=%0h/%0h exp=1/0", buble, stall_if); end
        tick();
        drive(1'b1, 5'd0, 5'd0, add1_cw, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_total++; if (buble !== 1'b1) begin n_bad++; $display("FAIL rl_c2_buble got=%0h exp=1", buble); end
        tick();
        @(negedge clk);
        n_total++; if (buble !== 1'b0) begin n_bad++; $display("FAIL rl_c3_buble got=%0h exp=0", buble); end
        n_total++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL rl_c3_ex_valid got=%0h exp=0", ex_valid); end
        tick();
        drive(1'b0, 5'd0, 5'd0, 26'd0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_total++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL rl_resume got=%0h exp=1", ex_valid); end
        tick();
        idle();
    endtask

    // beq held in EX for 3 cycles of ex_ready=0
    task automatic test_backpressure();
        logic [25:0] beq_cw;
        logic [25:0] add7_cw;
        beq_cw  = mk_cw(5'd0, 5'd2, 5'd1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        add7_cw = mk_cw(5'd7, 5'd9, 5'd8, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b1, 5'd1, 5'd2, beq_cw, 3'b010, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd8, 5'd9, add7_cw, 3'd0, 1'b0, 1'b0);
            @(negedge clk);
            n_total++; if (stall_if !== 1'b1 || buble !== 1'b0) begin n_bad++; $display("FAIL bp_ctrl[%0d] got=%0h/%0h exp=1/0", k, stall_if, buble); end
            n_total++; if (ex_control_word !== beq_cw || ex_branch_sel !== 3'b010) begin n_bad++; $display("FAIL bp_hold[%0d] got=%0h/%0h exp=%0h/2", k, ex_control_word, ex_branch_sel, beq_cw); end
            tick();
        end
        drive(1'b1, 5'd8, 5'd9, add7_cw, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_total++; if (stall_if !== 1'b0 || buble !== 1'b0) begin n_bad++; $display("FAIL bp_release got=%0h/%0h exp=0/0", stall_if, buble); end
        tick();
        drive(1'b0, 5'd0, 5'd0, 26'd0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_total++; if (ex_control_word !== add7_cw || ex_branch_sel !== 3'd0 || ex_valid !== 1'b1) begin n_bad++; $display("FAIL bp_next got=%0h/%0h/%0h exp=%0h/0/1", ex_control_word, ex_branch_sel, ex_valid, add7_cw); end
        tick();
        idle();
    endtask

    // Reset during the last load-use stall cycle
    task automatic test_reset_mid_stall();
        logic [25:0] lw_cw;
        logic [25:0] add_cw;
        lw_cw  = mk_cw(5'd5, 5'd0, 5'd10, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010);
        add_cw = mk_cw(5'd6, 5'd1, 5'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        drive(1'b1, 5'd10, 5'd0, lw_cw, 3'd0, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < c_NB_LOAD; k++) begin
            drive(1'b1, 5'd5, 5'd1, add_cw, 3'd0, 1'b1, 1'b0);
            @(negedge clk);
            n_total++; if (buble !== 1'b1) begin n_bad++; $display("FAIL rs_pre_buble[%0d] got=%0h exp=1", k, buble); end
            if (k == c_NB_LOAD - 1) begin
                reset = 1'b1;
                #1;
                n_total++; if (buble !== 1'b0 || stall_if !== 1'b0) begin n_bad++; $display("FAIL rs_now_ctrl got=%0h/%0h exp=0/0", buble, stall_if); end
                n_total++; if (ex_valid !== 1'b0 || ex_control_word !== 26'd0) begin n_bad++; $display("FAIL rs_now_ex got=%0h/%0h exp=0/0", ex_valid, ex_control_word); end
            end else begin
                tick();
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b1, 5'd5, 5'd1, add_cw, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_total++; if (buble !== 1'b0 || stall_if !== 1'b0) begin n_bad++; $display("FAIL rs_after_ctrl got=%0h/%0h exp=0/0", buble, stall_if); end
        tick();
        drive(1'b0, 5'd0, 5'd0, 26'd0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_total++; if (ex_control_word !== add_cw || ex_valid !== 1'b1) begin n_bad++; $display("FAIL rs_after_ex got=%0h/%0h exp=%0h/1", ex_control_word, ex_valid, add_cw); end
        tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_no_fwd();
        test_load_use();
        test_x0();
        test_flush();
        test_flush_reload();
        test_backpressure();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
